// File: rtl/prbs5_pkg.sv
// prbs5_pkg: shared definitions for the 5-bit PRBS (x^5 + x^2 + 1) checker.
//   - prbs5_state_e : checker FSM state encoding (HUNT, SYNC, LOCKED)
//   - PRBS5_LEN     : LFSR length / history depth
//   - PRBS5_PERIOD  : sequence period, also the error-window length
//   - PRBS5_TAP_A/B : recurrence taps, p[n] = h[n-3] ^ h[n-5]
package prbs5_pkg;

   localparam int PRBS5_LEN    = 5;
   localparam int PRBS5_PERIOD = 31;
   localparam int PRBS5_TAP_A  = 3;
   localparam int PRBS5_TAP_B  = 5;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } prbs5_state_e;

   // History holds the newest bit at the MSB, so a bit that is k samples
   // old sits at index PRBS5_LEN - k.
   function automatic int prbs5_hist_idx(input int tap);
      return PRBS5_LEN - tap;
   endfunction

endpackage

// File: rtl/prbs5_predict.sv
// prbs5_predict: combinational next-bit predictor for the 5-bit PRBS.
// Ports:
//   hist [4:0] in  : bit history, newest bit at hist[4]
//   pred       out : predicted next bit, h[n-3] ^ h[n-5]
//   zero       out : history is all zero (LFSR lockup pattern)
module prbs5_predict
   import prbs5_pkg::*;
(
   input  logic [PRBS5_LEN-1:0] hist,
   output logic                 pred,
   output logic                 zero
);

   localparam int IDX_A = prbs5_hist_idx(PRBS5_TAP_A);
   localparam int IDX_B = prbs5_hist_idx(PRBS5_TAP_B);

   assign pred = hist[IDX_A] ^ hist[IDX_B];
   assign zero = (hist == '0);

endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising receive checker for the 5-bit PRBS
// stream (x^5 + x^2 + 1, period 31). Acquires lock, then flags and counts
// every bit error, dropping lock when too many errors land in one window.
// Parameters:
//   LOCK_MATCHES (1..31) consecutive correct predictions to declare lock
//   LOSS_ERRS    (1..31) errors within one 31-bit window that drop lock
//   CNT_W                width of err_cnt
// Ports:
//   clk       in  : clock, rising edge
//   preset_n  in  : asynchronous active-low reset
//   din       in  : received serial bit
//   din_valid in  : din qualifier; everything holds while low
//   clr_cnt   in  : synchronous clear of err_cnt (wins over an increment)
//   locked    out : checker is in LOCKED
//   bit_err   out : one-cycle pulse per mismatched bit while locked
//   err_cnt   out : saturating bit-error count
// Build option: define PRBS5_CHK_ERR_CNT_EN to build the error counter;
// otherwise err_cnt is tied to zero and clr_cnt is ignored.
//
// state  | meaning
// HUNT   | filling the 5-bit history from din (fill count 0..5)
// SYNC   | predicting from din-fed history, counting consecutive matches
// LOCKED | local LFSR free-runs from its own prediction, din is only checked
module prbs5_checker
   import prbs5_pkg::*;
#(
   parameter int LOCK_MATCHES = 8,
   parameter int LOSS_ERRS    = 4,
   parameter int CNT_W        = 16
)(
   input  logic             clk,
   input  logic             preset_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [2:0] FILL_LAST = 3'(PRBS5_LEN - 1);
   localparam logic [4:0] LOCK_LAST = 5'(LOCK_MATCHES - 1);
   localparam logic [4:0] LOSS_TGT  = 5'(LOSS_ERRS);
   localparam logic [4:0] WIN_LAST  = 5'(PRBS5_PERIOD - 1);

   prbs5_state_e           state, state_nxt;
   logic [PRBS5_LEN-1:0]   hist, hist_nxt;
   logic [2:0]             fill_cnt, fill_nxt;
   logic [4:0]             match_cnt, match_nxt;
   logic [4:0]             win_pos, win_pos_nxt;
   logic [4:0]             win_err, win_err_nxt;
   logic [4:0]             win_err_sum;
   logic                   err_hit;
   logic                   pred;
   logic                   hist_zero;

   prbs5_predict u_predict (
      .hist (hist),
      .pred (pred),
      .zero (hist_zero)
   );

   always_comb begin
      state_nxt   = state;
      hist_nxt    = hist;
      fill_nxt    = fill_cnt;
      match_nxt   = match_cnt;
      win_pos_nxt = win_pos;
      win_err_nxt = win_err;
      win_err_sum = win_err;
      err_hit     = 1'b0;

      if (din_valid) begin
         case (state)
            HUNT: begin
               hist_nxt = {din, hist[PRBS5_LEN-1:1]};
               fill_nxt = fill_cnt + 3'd1;
               if (fill_cnt == FILL_LAST)
                  state_nxt = SYNC;
            end

            SYNC: begin
               hist_nxt = {din, hist[PRBS5_LEN-1:1]};
               // An all-zero history always predicts 0, so a zero stream
               // would otherwise "match" forever; treat it as a miss.
               if ((din != pred) || hist_zero) begin
                  match_nxt = 5'd0;
               end else if (match_cnt == LOCK_LAST) begin
                  state_nxt   = LOCKED;
                  match_nxt   = 5'd0;
                  win_pos_nxt = 5'd0;
                  win_err_nxt = 5'd0;
               end else begin
                  match_nxt = match_cnt + 5'd1;
               end
            end

            LOCKED: begin
               // Feeding the prediction back (not din) keeps a single line
               // error from corrupting the next two predictions.
               hist_nxt    = {pred, hist[PRBS5_LEN-1:1]};
               err_hit     = (din != pred);
               win_err_sum = win_err + {4'd0, err_hit};
               win_pos_nxt = (win_pos == WIN_LAST) ? 5'd0 : win_pos + 5'd1;
               if (err_hit && (win_err_sum == LOSS_TGT)) begin
                  state_nxt   = HUNT;
                  hist_nxt    = '0;
                  fill_nxt    = 3'd0;
                  win_pos_nxt = 5'd0;
                  win_err_nxt = 5'd0;
               end else if (win_pos == WIN_LAST) begin
                  win_err_nxt = 5'd0;
               end else begin
                  win_err_nxt = win_err_sum;
               end
            end

            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         state     <= HUNT;
         hist      <= '0;
         fill_cnt  <= 3'd0;
         match_cnt <= 5'd0;
         win_pos   <= 5'd0;
         win_err   <= 5'd0;
         locked    <= 1'b0;
         bit_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         fill_cnt  <= fill_nxt;
         match_cnt <= match_nxt;
         win_pos   <= win_pos_nxt;
         win_err   <= win_err_nxt;
         locked    <= (state_nxt == LOCKED);
         bit_err   <= err_hit;
      end
   end

`ifdef PRBS5_CHK_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n)
         err_cnt_q <= '0;
      else if (clr_cnt)
         err_cnt_q <= '0;
      else if (err_hit && (err_cnt_q != '1))
         err_cnt_q <= err_cnt_q + CNT_ONE;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_clr_cnt;

   assign unused_clr_cnt = clr_cnt;
   assign err_cnt        = '0;
`endif

endmodule
